// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: LSB-first operands framed by start,
// combinational sum bit plus a parallel result, carry-out and overflow per frame.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             sub,
    input  logic             a,
    input  logic             b,
    output logic             q,
    output logic             state,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} phase_t;
    phase_t phase, phase_nxt;

    logic             mode;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             active, mode_eff, cin, be, s, cn, last;

    // Before the frame starts, sub doubles as carry-in so subtract is a + ~b + 1.
    always_comb begin
        active   = busy | start;
        mode_eff = busy ? mode : sub;
        cin      = busy ? state : sub;
        be       = b ^ mode_eff;
        s        = a ^ be ^ cin;
        cn       = (a & be) | (cin & (a ^ be));
        last     = busy && (cnt == CW'(WIDTH - 1));
    end

    assign q = active & s;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) phase <= IDLE;
        else         phase <= phase_nxt;
    end

    always_comb begin
        phase_nxt = phase;
        case (phase)
            IDLE:    if (start) phase_nxt = RUN;
            RUN:     if (last)  phase_nxt = IDLE;
            default: phase_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (phase == RUN);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= 1'b0;
            mode     <= 1'b0;
            cnt      <= '0;
            shreg    <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy && start) begin
                mode  <= sub;
                state <= cn;
                shreg <= {s, shreg[WIDTH-1:1]};
                cnt   <= CW'(1);
            end else if (busy) begin
                shreg <= {s, shreg[WIDTH-1:1]};
                if (last) begin
                    cnt      <= '0;
                    state    <= 1'b0;
                    result   <= {s, shreg[WIDTH-1:1]};
                    cout     <= cn;
                    overflow <= cn ^ cin;
                    done     <= 1'b1;
                end else begin
                    state <= cn;
                    cnt   <= cnt + CW'(1);
                end
            end
        end
    end
endmodule
